piso_shift_register: RTL and testbench

//   Parallel-in/serial-out shift register with valid/ready load handshake; the

---
 rtl/piso_shift_register_if.sv | 33 +++
 rtl/piso_shift_register.sv | 112 +++++++++++
 tb/tb_piso_shift_register.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_register_if.sv
// Load handshake and serial output bundle for the PISO transmitter.
// The master drives words in; the slave (the shifter) drives the serial side.
interface piso_shift_register_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sdo;
  logic             sdo_valid;
  logic             done;
  logic             busy;

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  sdo,
    input  sdo_valid,
    input  done,
    input  busy
  );

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output sdo,
    output sdo_valid,
    output done,
    output busy
  );
endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in / serial-out transmitter with a valid/ready load handshake.
// A word occupies exactly WIDTH consecutive sdo_valid cycles. A new word can
// be accepted on the last bit of the current one, so back-to-back words leave
// no gap. All outputs come from registered state; load_ready is also gated by
// rst_n so nothing is accepted while reset is asserted.
module piso_shift_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piso_shift_register_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] count_q;   // bits remaining in the word, minus one
  logic             last_bit;
  logic             ready;
  logic             accept;
  logic             load_word;
  logic             shift_en;

  // Advance the register by one bit toward the output end, zero filling.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  // Bit currently presented at the output end of the register.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return v[WIDTH-1];
    end else begin
      return v[0];
    end
  endfunction

  assign last_bit = (count_q == '0);
  assign ready    = rst_n & ((state_q == IDLE) | ((state_q == SHIFT) & last_bit));
  assign accept   = bus.load_valid & ready;

  assign bus.load_ready = ready;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.sdo_valid  = (state_q == SHIFT);
  assign bus.done       = (state_q == SHIFT) & last_bit;
  assign bus.sdo        = (state_q == SHIFT) & out_bit(shreg_q);

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls: load on accept, otherwise shift mid-word.
  always_comb begin
    state_d   = state_q;
    load_word = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load_word = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shift_en = 1'b1;
        end else if (accept) begin
          load_word = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      count_q <= '0;
    end else if (load_word) begin
      shreg_q <= bus.din;
      count_q <= CNT_LAST;
    end else if (shift_en) begin
      shreg_q <= shift_one(shreg_q);
      count_q <= count_q - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: four instances covering 8-bit MSB/LSB first,
// 2-bit and 32-bit words, checked every cycle against a word-level model plus
// a SIPO capture scoreboard, and pinned with hand-computed bit sequences.
module tb_piso_shift_register;

  localparam int NI          = 4;
  localparam int WID  [NI]   = '{8, 8, 2, 32};
  localparam bit MSBF [NI]   = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0]   din_a [NI];
  logic [NI-1:0] lv;
  logic [NI-1:0] sdo_o, vld_o, done_o, busy_o, rdy_o;

  always #5 clk = ~clk;

  piso_shift_register_if #(.WIDTH(8))  if0 ();
  piso_shift_register_if #(.WIDTH(8))  if1 ();
  piso_shift_register_if #(.WIDTH(2))  if2 ();
  piso_shift_register_if #(.WIDTH(32)) if3 ();

  piso_shift_register #(.WIDTH(8),  .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  piso_shift_register #(.WIDTH(8),  .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  piso_shift_register #(.WIDTH(2),  .MSB_FIRST(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  piso_shift_register #(.WIDTH(32), .MSB_FIRST(1'b0)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  assign if0.din = din_a[0][7:0];
  assign if1.din = din_a[1][7:0];
  assign if2.din = din_a[2][1:0];
  assign if3.din = din_a[3];
  assign if0.load_valid = lv[0];
  assign if1.load_valid = lv[1];
  assign if2.load_valid = lv[2];
  assign if3.load_valid = lv[3];
  assign sdo_o  = {if3.sdo,        if2.sdo,        if1.sdo,        if0.sdo};
  assign vld_o  = {if3.sdo_valid,  if2.sdo_valid,  if1.sdo_valid,  if0.sdo_valid};
  assign done_o = {if3.done,       if2.done,       if1.done,       if0.done};
  assign busy_o = {if3.busy,       if2.busy,       if1.busy,       if0.busy};
  assign rdy_o  = {if3.load_ready, if2.load_ready, if1.load_ready, if0.load_ready};

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int i);
    logic [63:0] m;
    m = (64'd1 << WID[i]) - 64'd1;
    return m[31:0];
  endfunction

  // Model: per instance, the word being sent and how many of its bits are
  // still to appear (including the one on the wire this cycle).
  int          rem  [NI];
  logic [31:0] word [NI];

  function automatic logic exp_bit(input int i);
    int p;
    int idx;
    p   = WID[i] - rem[i];
    idx = MSBF[i] ? (WID[i] - 1 - p) : p;
    return word[i][idx];
  endfunction

  // Model update: a word is taken when offered while at most one bit remains.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        rem[i] <= 0;
      end else if (lv[i] && (rem[i] <= 1)) begin
        word[i] <= din_a[i] & mask_of(i);
        rem[i]  <= WID[i];
      end else if (rem[i] > 0) begin
        rem[i] <= rem[i] - 1;
      end
    end
  end

  // Compare every output of every instance against the model each cycle, and
  // reassemble each word the way a receiving SIPO would.
  logic [31:0] cap [NI];
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check("sdo_valid",  i, vld_o[i],  rem[i] > 0);
      check("busy",       i, busy_o[i], rem[i] > 0);
      check("done",       i, done_o[i], rem[i] == 1);
      check("load_ready", i, rdy_o[i],  rst_n && (rem[i] <= 1));
      check("sdo",        i, sdo_o[i],  (rem[i] > 0) ? exp_bit(i) : 1'b0);
      if (vld_o[i]) begin
        if (MSBF[i]) cap[i] = {cap[i][30:0], sdo_o[i]};
        else         cap[i] = {sdo_o[i], cap[i][31:1]};
        if (done_o[i] && rem[i] == 1) begin
          check("sipo_word", i,
                MSBF[i] ? (cap[i] & mask_of(i)) : (cap[i] >> (32 - WID[i])),
                word[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] e;

  initial begin
    lv = '0;
    for (int i = 0; i < NI; i++) din_a[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 0, rdy_o,  4'h0);
    check("rst_valid", 0, vld_o,  4'h0);
    check("rst_sdo",   0, sdo_o,  4'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 0, rdy_o, 4'hF);
    check("post_rst_sdo",   0, sdo_o, 4'h0);

    // A5 MSB first on inst0 and LSB first on inst1
    e = 8'hA5;
    din_a[0] = 32'hA5;
    din_a[1] = 32'hA5;
    step();
    lv = 4'b0011;
    step();
    lv = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("a5_msb_sdo",  0, sdo_o[0],  e[7-k]);
      check("a5_msb_done", 0, done_o[0], k == 7);
      check("a5_lsb_sdo",  1, sdo_o[1],  e[k]);
    end
    step();

    // 01 LSB first: one then seven zeros
    din_a[1] = 32'h01;
    lv[1] = 1'b1;
    step();
    lv[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("h01_lsb_sdo", 1, sdo_o[1], k == 0);
    end
    step();

    // Back-to-back FF then 00 with load_valid held
    din_a[0] = 32'hFF;
    lv[0] = 1'b1;
    step();
    din_a[0] = 32'h00;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("b2b_sdo",   0, sdo_o[0],  k <= 8);
      check("b2b_valid", 0, vld_o[0],  1'b1);
      check("b2b_done",  0, done_o[0], (k == 8) || (k == 16));
      check("b2b_ready", 0, rdy_o[0],  (k == 8) || (k == 16));
      if (k == 8) begin
        step();
        lv[0] = 1'b0;
      end
    end
    step();

    // Changing din with load_valid high mid-word is ignored
    e = 8'hA5;
    din_a[0] = 32'hA5;
    lv[0] = 1'b1;
    step();
    din_a[0] = $urandom;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("ign_ready", 0, rdy_o[0], k == 8);
      check("ign_sdo",   0, sdo_o[0], e[8-k]);
      step();
      if (k >= 7) lv[0] = 1'b0;
      din_a[0] = $urandom;
    end
    step();

    // Reset mid-word takes effect immediately
    for (int i = 0; i < NI; i++) din_a[i] = 32'h5AC3_96E1;
    lv = 4'hF;
    step();
    lv = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 0, vld_o,  4'h0);
    check("mid_rst_done",  0, done_o, 4'h0);
    check("mid_rst_busy",  0, busy_o, 4'h0);
    check("mid_rst_ready", 0, rdy_o,  4'h0);
    check("mid_rst_sdo",   0, sdo_o,  4'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 0, rdy_o, 4'hF);
    check("rel_sdo",   0, sdo_o, 4'h0);

    // Fresh word after reset starts from the first bit
    e = 8'h3C;
    din_a[0] = 32'h3C;
    step();
    lv[0] = 1'b1;
    step();
    lv[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fresh_sdo", 0, sdo_o[0], e[7-k]);
    end
    step();

    // Random words and gaps on all instances
    repeat (600) begin
      step();
      for (int i = 0; i < NI; i++) begin
        lv[i]    = ($urandom_range(0, 3) != 0);
        din_a[i] = $urandom;
      end
    end
    lv = '0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
